writeback_unit: RTL



---
 rtl/writeback_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/writeback_unit.sv
// Writeback stage: merges ALU results and fixed-latency loads onto the single
// register-file write port, with a one-entry skid buffer for collisions.
module writeback_unit #(
    parameter int W        = 8,
    parameter int D        = 3,
    parameter int LOAD_LAT = 2
) (
    input  logic         CLK,
    input  logic         Reset_n,
    input  logic         Alu_valid,
    input  logic [D-1:0] Alu_dest,
    input  logic [W-1:0] Alu_data,
    output logic         Alu_ready,
    input  logic         Load_start,
    input  logic [D-1:0] Load_dest,
    output logic         Load_accept,
    input  logic [W-1:0] Mem_data,
    input  logic [D-1:0] Src0_addr,
    input  logic [D-1:0] Src1_addr,
    output logic         Hazard,
    output logic         Busy,
    output logic         Reg_write_en,
    output logic [D-1:0] Reg_write_address,
    output logic [W-1:0] Reg_write_data,
    output logic [1:0]   Dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_RETURN = 2'd2
    } state_e;

    localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

    state_e       state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [D-1:0] pend_dest_q, pend_dest_d;

    logic         skid_valid_q, skid_valid_d;
    logic [D-1:0] skid_dest_q, skid_dest_d;
    logic [W-1:0] skid_data_q, skid_data_d;

    logic         wr_en_q, wr_en_d;
    logic [D-1:0] wr_addr_q, wr_addr_d;
    logic [W-1:0] wr_data_q, wr_data_d;

    logic         alu_fire;
    logic         load_ret;
    logic         sel_valid;
    logic [D-1:0] sel_dest;
    logic [W-1:0] sel_data;
    logic         src_match_pend;
    logic         src_match_new;

    // Handshakes: an ALU result transfers when Alu_valid && Alu_ready in the
    // same cycle; a load request transfers when Load_start && Load_accept.
    // Requesters hold their request until it transfers.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            pend_dest_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_dest_q  <= '0;
            skid_data_q  <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_dest_q  <= pend_dest_d;
            skid_valid_q <= skid_valid_d;
            skid_dest_q  <= skid_dest_d;
            skid_data_q  <= skid_data_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_dest_d = pend_dest_q;
        Load_accept = 1'b0;
        case (state_q)
            S_IDLE: begin
                Load_accept = Load_start;
                if (Load_start) begin
                    pend_dest_d = Load_dest;
                    cnt_d       = LAT_M1;
                    state_d     = (LOAD_LAT == 1) ? S_RETURN : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = S_RETURN;
                end
            end
            S_RETURN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Alu_ready = !skid_valid_q;
    assign alu_fire  = Alu_valid && Alu_ready;
    assign load_ret  = (state_q == S_RETURN);

    // Priority: load return, then skid entry, then a fresh ALU result. An ALU
    // result beaten by a load return parks in the skid, so the older load
    // value is written first and the program-later ALU value lands last.
    always_comb begin
        skid_valid_d = skid_valid_q;
        skid_dest_d  = skid_dest_q;
        skid_data_d  = skid_data_q;
        sel_valid    = 1'b0;
        sel_dest     = '0;
        sel_data     = '0;
        if (load_ret) begin
            sel_valid = 1'b1;
            sel_dest  = pend_dest_q;
            sel_data  = Mem_data;
            if (alu_fire) begin
                skid_valid_d = 1'b1;
                skid_dest_d  = Alu_dest;
                skid_data_d  = Alu_data;
            end
        end else if (skid_valid_q) begin
            sel_valid    = 1'b1;
            sel_dest     = skid_dest_q;
            sel_data     = skid_data_q;
            skid_valid_d = 1'b0;
        end else if (alu_fire) begin
            sel_valid = 1'b1;
            sel_dest  = Alu_dest;
            sel_data  = Alu_data;
        end
    end

    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (sel_valid) begin
            wr_en_d   = (sel_dest != '0);
            wr_addr_d = sel_dest;
            wr_data_d = sel_data;
        end
    end

    assign Busy = (state_q != S_IDLE);

    // Register 0 is never written, so it can never be a real hazard.
    assign src_match_pend = (pend_dest_q != '0) &&
                            ((Src0_addr == pend_dest_q) || (Src1_addr == pend_dest_q));
    assign src_match_new  = (Load_dest != '0) &&
                            ((Src0_addr == Load_dest) || (Src1_addr == Load_dest));
    assign Hazard = (Busy && src_match_pend) ||
                    ((state_q == S_IDLE) && Load_start && src_match_new);

    assign Reg_write_en      = wr_en_q;
    assign Reg_write_address = wr_addr_q;
    assign Reg_write_data    = wr_data_q;
    assign Dbg_state         = state_q;

endmodule
